// File: rtl/pose_result_serializer_pkg.sv
// Shared widths, stream constants, buffered-result record and serializer FSM states.
// Optional sigma words are enabled with POSE_SERIAL_SIGMA_EN.
package RgbdVoConfigPk;

  localparam int POSE_BW     = 42;
  localparam int CLOUD_BW    = 42;
  localparam int DATA_RGB_BW = 8;

  localparam logic [7:0] POSE_SERIAL_SYNC = 8'hA5;

`ifdef POSE_SERIAL_SIGMA_EN
  localparam logic [15:0] POSE_SERIAL_PAYLOAD = 16'd28;
`else
  localparam logic [15:0] POSE_SERIAL_PAYLOAD = 16'd24;
`endif

  typedef struct packed {
    logic                          f_or_d;
    logic [3:0]                    seq;
    logic [11:0][POSE_BW-1:0]      pose;
`ifdef POSE_SERIAL_SIGMA_EN
    logic [2*CLOUD_BW-1:0]         sigma_icp;
    logic [DATA_RGB_BW:0]          sigma_rgbd;
`endif
  } pose_result_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_POSE
`ifdef POSE_SERIAL_SIGMA_EN
    , ST_SIGMA
`endif
  } ser_state_e;

  function automatic logic [31:0] header_word(input logic f_or_d, input logic [3:0] seq);
    return {POSE_SERIAL_SYNC, f_or_d, seq, 3'b000, POSE_SERIAL_PAYLOAD};
  endfunction

endpackage

// File: rtl/pose_result_serializer_buffer.sv
// Two-entry result FIFO; a push is accepted while full if a pop happens in the same cycle.
// Also exposes the header fields of the entry behind the head for gap-free packet chaining.
module pose_result_buffer
  import RgbdVoConfigPk::*;
(
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  pose_result_t i_data,
  output pose_result_t o_head,
  output logic         o_next_f_or_d,
  output logic [3:0]   o_next_seq,
  output logic [1:0]   o_count,
  output logic         o_full,
  output logic         o_empty
);

  pose_result_t mem_q [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  always_comb begin
    do_pop   = i_pop && (count_q != 2'd0);
    do_push  = i_push && ((count_q != 2'd2) || do_pop);
    wr_ptr_d = do_push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = do_pop ? ~rd_ptr_q : rd_ptr_q;
    count_d  = count_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; count_q alone decides which slots are valid.
  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_data;
  end

  assign o_head        = mem_q[rd_ptr_q];
  assign o_next_f_or_d = mem_q[~rd_ptr_q].f_or_d;
  assign o_next_seq    = mem_q[~rd_ptr_q].seq;
  assign o_count       = count_q;
  assign o_full        = (count_q == 2'd2);
  assign o_empty       = (count_q == 2'd0);

endmodule

// File: rtl/pose_result_serializer.sv
// Captures pose/sigma results on i_update_done and streams them as framed 32-bit words.
// Define POSE_SERIAL_SIGMA_EN to append the four sigma words to each packet.
module pose_result_serializer #(
  parameter int POSE_BW       = RgbdVoConfigPk::POSE_BW,
  parameter int SIGMA_ICP_BW  = 2 * RgbdVoConfigPk::CLOUD_BW,
  parameter int SIGMA_RGBD_BW = RgbdVoConfigPk::DATA_RGB_BW + 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_update_done,
  input  logic                      i_f_or_d,
  input  logic [11:0][POSE_BW-1:0]  i_pose,
  input  logic [SIGMA_ICP_BW-1:0]   i_sigma_icp,
  input  logic [SIGMA_RGBD_BW-1:0]  i_sigma_rgbd,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [31:0]               o_data,
  output logic                      o_last,
  output logic [7:0]                o_drop_cnt,
  output logic                      o_busy
);
  import RgbdVoConfigPk::*;

  pose_result_t cap_entry, head;
  logic         buf_next_fd;
  logic [3:0]   buf_next_seq;
  logic [1:0]   buf_count, cnt_next;
  logic         buf_full, buf_empty;
  logic         push, pop, hs, nxt_avail, nxt_fd;
  logic [3:0]   nxt_seq;

  ser_state_e   state_q, state_d;
  logic [4:0]   idx_q, idx_d;
  logic [3:0]   seq_q, seq_d;
  logic [7:0]   drop_q, drop_d;
  logic         valid_q, valid_d, last_q, last_d, busy_q, busy_d;
  logic [31:0]  data_q, data_d;

  function automatic logic [31:0] pose_word(input pose_result_t r, input logic [4:0] idx);
    logic [POSE_BW-1:0] p;
    logic [63:0]        ext;
    p   = r.pose[idx[4:1]];
    ext = {{(64-POSE_BW){p[POSE_BW-1]}}, p};
    return idx[0] ? ext[63:32] : ext[31:0];
  endfunction

`ifdef POSE_SERIAL_SIGMA_EN
  function automatic logic [31:0] sigma_word(input pose_result_t r, input logic [1:0] idx);
    logic [95:0] icp_ext;
    icp_ext = 96'(r.sigma_icp);
    case (idx)
      2'd0:    return icp_ext[31:0];
      2'd1:    return icp_ext[63:32];
      2'd2:    return icp_ext[95:64];
      default: return 32'(r.sigma_rgbd);
    endcase
  endfunction
`else
  logic unused_sigma;
  assign unused_sigma = ^{i_sigma_icp, i_sigma_rgbd};
`endif

  always_comb begin
    cap_entry        = '0;
    cap_entry.f_or_d = i_f_or_d;
    cap_entry.seq    = seq_q;
    cap_entry.pose   = i_pose;
`ifdef POSE_SERIAL_SIGMA_EN
    cap_entry.sigma_icp  = i_sigma_icp;
    cap_entry.sigma_rgbd = i_sigma_rgbd;
`endif
  end

  pose_result_buffer u_buf (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_push        (push),
    .i_pop         (pop),
    .i_data        (cap_entry),
    .o_head        (head),
    .o_next_f_or_d (buf_next_fd),
    .o_next_seq    (buf_next_seq),
    .o_count       (buf_count),
    .o_full        (buf_full),
    .o_empty       (buf_empty)
  );

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    hs      = valid_q && i_ready;
    pop     = 1'b0;
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;

    case (state_q)
      ST_IDLE: if (!buf_empty) begin
        state_d = ST_HDR;
        valid_d = 1'b1;
        data_d  = header_word(head.f_or_d, head.seq);
        last_d  = 1'b0;
      end
      ST_HDR: if (hs) begin
        state_d = ST_POSE;
        idx_d   = 5'd0;
        data_d  = pose_word(head, 5'd0);
        last_d  = 1'b0;
      end
      ST_POSE: if (hs) begin
        if (idx_q != 5'd23) begin
          idx_d  = idx_q + 5'd1;
          data_d = pose_word(head, idx_d);
`ifdef POSE_SERIAL_SIGMA_EN
          last_d = 1'b0;
        end else begin
          state_d = ST_SIGMA;
          idx_d   = 5'd0;
          data_d  = sigma_word(head, 2'd0);
          last_d  = 1'b0;
        end
      end
      ST_SIGMA: if (hs) begin
        if (idx_q != 5'd3) begin
          idx_d  = idx_q + 5'd1;
          data_d = sigma_word(head, idx_d[1:0]);
          last_d = (idx_d == 5'd3);
        end else begin
          pop = 1'b1;
        end
      end
`else
          last_d = (idx_d == 5'd23);
        end else begin
          pop = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // A full buffer still accepts a capture when the final word is popped this cycle.
    push      = i_update_done && (!buf_full || pop);
    nxt_avail = (buf_count == 2'd2) || push;
    nxt_fd    = (buf_count == 2'd2) ? buf_next_fd : i_f_or_d;
    nxt_seq   = (buf_count == 2'd2) ? buf_next_seq : seq_q;

    if (pop) begin
      last_d = 1'b0;
      if (nxt_avail) begin
        state_d = ST_HDR;
        valid_d = 1'b1;
        data_d  = header_word(nxt_fd, nxt_seq);
      end else begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        data_d  = 32'd0;
      end
    end

    seq_d  = push ? seq_q + 4'd1 : seq_q;
    drop_d = (i_update_done && !push && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    cnt_next = buf_count + {1'b0, push} - {1'b0, pop};
    busy_d   = (cnt_next != 2'd0);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 5'd0;
      seq_q   <= 4'd0;
      drop_q  <= 8'd0;
      valid_q <= 1'b0;
      data_q  <= 32'd0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      seq_q   <= seq_d;
      drop_q  <= drop_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end

  assign o_valid    = valid_q;
  assign o_data     = data_q;
  assign o_last     = last_q;
  assign o_drop_cnt = drop_q;
  assign o_busy     = busy_q;

endmodule

// File: doc/pose_result_serializer.md
# pose_result_serializer

Output-side companion to the VO chip top: captures each pose/sigma result the chip publishes on `o_update_done` and streams it off-chip as 32-bit words over a valid/ready stream, framed by a header word. It sits directly after the chip top's pose/sigma outputs. It lets the host, or a downstream DMA, read results at its own pace without stalling the pose pipeline. A 2-entry result buffer absorbs back-to-back updates.

## Interface
- `POSE_BW`, default from package (42): width of one signed pose element.
- `SIGMA_ICP_BW`, default 2*CLOUD_BW (84): ICP sigma width.
- `SIGMA_RGBD_BW`, default DATA_RGB_BW+1 (9): RGBD sigma width.
- `i_clk`  in  1  sole clock; all logic on its rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_update_done`  in  1  single-cycle strobe; pose/sigma inputs valid this cycle.
- `i_f_or_d`  in  1  0 = feature phase, 1 = direct phase; latched at capture.
- `i_pose`  in  12 x POSE_BW  signed pose Rt[0..11].
- `i_sigma_icp`  in  SIGMA_ICP_BW  next ICP sigma.
- `i_sigma_rgbd`  in  SIGMA_RGBD_BW  next RGBD sigma.
- `o_valid`  out  1  stream word valid.
- `i_ready`  in  1  downstream accepts word.
- `o_data`  out  32  stream word.
- `o_last`  out  1  final word of a result packet.
- `o_drop_cnt`  out  8  saturating count of dropped results.
- `o_busy`  out  1  buffer non-empty or packet in flight.

## Operation
- Capture: on `i_update_done`, write {f_or_d, seq, pose, sigmas} into the free buffer slot. `seq` is a 4-bit capture counter: it increments per accepted capture and wraps 15 -> 0.
- Buffer full at capture: drop the result, do not advance `seq`, and increment `o_drop_cnt` (saturate at 255).
- Capture in the same cycle as the last-word handshake of a full buffer: the slot frees and the capture is accepted, with no drop.
- Packet words, in order:
  - Header: [31:24]=8'hA5, [23]=f_or_d, [22:19]=seq, [18:16]=0, [15:0]=payload word count (24, or 28 with sigma).
  - Pose: for k = 0..11, Rt[k] is sign-extended to 64 bits and sent low word, then high word.
  - Sigma (if enabled): ICP sigma zero-extended to 96 bits and sent as three words, low first; then RGBD sigma zero-extended to 32 bits.
- `o_last` is high only on the final word.
- FSM states:
  - IDLE -> HDR when the buffer is non-empty.
  - HDR -> POSE on handshake.
  - POSE (word index 0..23) -> SIGMA, or -> IDLE/HDR after index 23.
  - SIGMA (index 0..3) -> IDLE/HDR after index 3.
  - A slot is popped on the last-word handshake. The next packet's HDR follows with no idle cycle if the buffer is still non-empty.
- Stream rule: once `o_valid` is high, `o_data`/`o_last` hold stable until `i_ready`. `o_valid` never drops without a handshake.
- Internal arithmetic: word index 5 bits; sign extension via replication of bit POSE_BW-1.

## Timing
- Reset values: `o_valid`=0, `o_data`=0, `o_last`=0, `o_drop_cnt`=0, `o_busy`=0. Internally, `seq`=0, buffer empty, FSM in IDLE.
- Latency: `i_update_done` in cycle N with an empty buffer -> header with `o_valid`=1 from cycle N+2.
- Throughput: one word per cycle while `i_ready`=1. A 25-word packet (29 with sigma) completes 25 (29) cycles after the header appears.
- Reset mid-packet: the packet is discarded and the buffer cleared. `o_valid`=0 in the cycle after reset is sampled, and no partial packet resumes.
- `o_busy` is registered: high the cycle after capture, low the cycle after the final pop.

## Configuration
- `POSE_SERIAL_SIGMA_EN`:
  - Defined: SIGMA words are emitted; payload count is 28; the buffer stores sigma fields.
  - Undefined: no sigma storage or SIGMA state; payload count is 24; `o_last` is on pose word 23; sigma inputs are ignored.

## Structure
- RgbdVoConfigPk holds:
  - existing POSE_BW, CLOUD_BW, DATA_RGB_BW;
  - new POSE_SERIAL_SYNC (8'hA5);
  - a packed struct typedef `pose_result_t` {f_or_d, seq, pose, sigma_icp, sigma_rgbd};
  - an enum typedef for FSM states.
- Sub-module `pose_result_buffer`: 2-entry FIFO of `pose_result_t` with push/pop/full/empty. It handles simultaneous push+pop when full.

## Test plan
- Identity pose (Rt[0]=Rt[5]=Rt[10]=16777216, others 0), f_or_d=0, `i_ready`=1 -> header 0xA5000018 (0xA500001C with sigma), word1=0x01000000, word2=0, `o_last` on word 24 (28).
- Rt[3] = -1 -> words 7/8 = 0xFFFFFFFF/0xFFFFFFFF. Check sign extension of the 42-bit value.
- `i_ready` toggling 1,0,0,1 -> no word duplicated or skipped; `o_data` stable while stalled.
- Three strobes 1 cycle apart with `i_ready`=0 -> two packets buffered (seq 0, 1); `o_drop_cnt`=1.
- 17 back-to-back accepted packets -> seq wraps 15 -> 0 in header bits [22:19].
- Assert `i_rst` at word 10 -> `o_valid`=0 next cycle; the next strobe produces a packet with seq=0.
